// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: state encoding and shared constants for the serial transmit arbiter.
package serial_tx_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_START_TIMEOUT = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT_START = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_GAP = 3'd5;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: find-first-set over req starting at ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W-1:0] j;
  // Scan from the farthest slot back toward ptr so the nearest hit wins.
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      idx = req[j] ? j : idx;
    end
  end
  assign valid = |req;
  assign onehot = valid ? N'(1) << idx : '0;
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one serial transmitter among NUM_REQ byte clients.
module serial_tx_arbiter
  import serial_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_send,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      err
);
  localparam int IDX_W = $clog2(NUM_REQ);
  logic [1:0] rst_sync;
  logic arst_n;
  logic [2:0] state;
  logic [IDX_W-1:0] rr, cur, pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic pick_valid, timeout, fin;
  logic [7:0] tocnt;
  logic [3:0] gapcnt;
  logic [BYTE_W-1:0] pick_byte;
  // Reset asserts immediately but releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign arst_n = rst_sync[1];
  rr_priority_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
    .req(req),
    .ptr(rr),
    .onehot(pick_onehot),
    .idx(pick_idx),
    .valid(pick_valid)
  );
  assign pick_byte = req_data[BYTE_W*pick_idx +: BYTE_W];
  assign timeout = state == ST_WAIT_START && !tx_busy && tocnt == 8'(START_TIMEOUT - 1);
  assign fin = timeout || (state == ST_WAIT_DONE && !tx_busy);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      ack <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
      err <= 1'b0;
      rr <= '0;
      cur <= '0;
      tocnt <= '0;
      gapcnt <= '0;
    end else begin
      ack <= '0;
      tx_send <= 1'b0;
      case (state)
        ST_IDLE:
          if (pick_valid) begin
            grant <= pick_onehot;
            cur <= pick_idx;
            tx_data <= pick_byte;
            state <= ST_LOAD;
          end
        ST_LOAD: begin
          tx_send <= 1'b1;
          state <= ST_SEND;
        end
        ST_SEND: begin
          tocnt <= '0;
          state <= ST_WAIT_START;
        end
        ST_WAIT_START:
          if (tx_busy) state <= ST_WAIT_DONE;
          else tocnt <= tocnt + 8'd1;
        ST_WAIT_DONE: ;
        ST_GAP:
          if (gapcnt == 4'(GAP_CYCLES - 1)) state <= ST_IDLE;
          else gapcnt <= gapcnt + 4'd1;
        default: state <= ST_IDLE;
      endcase
      // A timed-out frame is retired exactly like a completed one, plus the sticky error.
      if (fin) begin
        ack <= grant;
        grant <= '0;
        rr <= (cur == IDX_W'(NUM_REQ - 1)) ? '0 : cur + IDX_W'(1);
        gapcnt <= '0;
        state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      if (timeout) err <= 1'b1;
    end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: scoreboard bench with client and transmitter models for serial_tx_arbiter.
module tb_serial_tx_arbiter;
  localparam int N = 4;
  localparam int GAP = 2;
  localparam int TO = 8;
  localparam int BUSY_LEN = 8;
  typedef struct {
    int idx;
    logic [7:0] data;
  } exp_t;
  logic clk, rst_n, tx_send, tx_busy, err;
  logic [N-1:0] req, ack, grant, grant_q;
  logic [8*N-1:0] req_data;
  logic [7:0] tx_data;
  logic err_q, chk_gap, have_ack;
  logic [N-1:0] sent_grant;
  exp_t sb[$];
  exp_t e;
  int pend[N];
  int n_checks, n_fail, ack_cnt, cyc, send_cyc, ack_cyc, busy_cnt, mute_sends;

  serial_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .START_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .grant(grant),
    .tx_send(tx_send),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_frame(input int idx);
    exp_t x;
    x.idx = idx;
    x.data = req_data[8*idx +: 8];
    sb.push_back(x);
  endtask

  task automatic wait_acks(input int n);
    int tgt = ack_cnt + n;
    for (int k = 0; k < 400 && ack_cnt < tgt; k++) begin
      @(posedge clk);
      #2;
    end
    check("acks", ack_cnt, tgt);
  endtask

  task automatic wait_grant(input logic [N-1:0] g);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (grant == g) break;
    end
    check("grant_wait", grant, g);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Client, transmitter and scoreboard models, all evaluated away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy_cnt = 0;
      tx_busy = 1'b0;
      sent_grant = '0;
      have_ack = 1'b0;
      grant_q = '0;
      err_q = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        tx_busy = busy_cnt != 0;
      end else if (tx_send) begin
        if (mute_sends > 0) mute_sends--;
        else begin
          busy_cnt = BUSY_LEN;
          tx_busy = 1'b1;
        end
      end
      if (tx_send) begin
        if (sb.size() == 0) check("send_unexpected", 0, 1);
        else begin
          e = sb.pop_front();
          check("send_grant", grant, 1 << e.idx);
          check("send_data", tx_data, e.data);
        end
        sent_grant = grant;
        send_cyc = cyc;
      end
      if (ack != 0) begin
        check("ack_owner", ack, sent_grant);
        sent_grant = '0;
        ack_cnt++;
        ack_cyc = cyc;
        have_ack = 1'b1;
        for (int i = 0; i < N; i++) if (ack[i] && pend[i] > 0) pend[i]--;
      end
      if (err && !err_q) begin
        check("err_delay", cyc - send_cyc, TO + 1);
        check("err_with_ack", |ack, 1);
      end
      if (grant != 0 && grant_q == 0 && chk_gap && have_ack) check("gap", cyc - ack_cyc, GAP + 1);
      grant_q = grant;
      err_q = err;
    end
    for (int i = 0; i < N; i++) req[i] = pend[i] != 0;
  end

  initial begin
    rst_n = 1'b0;
    tx_busy = 1'b0;
    req = '0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    chk_gap = 1'b0;
    mute_sends = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_err", err, 0);
    do_reset();
    chk_gap = 1'b1;
    req_data[15:8] = 8'hA5;
    expect_frame(1);
    expect_frame(1);
    pend[1] = 2;
    @(posedge clk);
    #1;
    check("single_grant", grant, 4'b0010);
    check("single_data", tx_data, 8'hA5);
    check("single_no_send_yet", tx_send, 0);
    @(posedge clk);
    #1;
    check("single_send", tx_send, 1);
    @(posedge clk);
    #1;
    check("single_send_pulse", tx_send, 0);
    wait_acks(2);
    do_reset();
    req_data[15:8] = 8'h22;
    for (int i = 0; i < N; i++) expect_frame(i);
    expect_frame(0);
    pend[0] = 2;
    pend[1] = 1;
    pend[2] = 1;
    pend[3] = 1;
    wait_acks(5);
    expect_frame(2);
    pend[2] = 1;
    wait_acks(1);
    expect_frame(3);
    expect_frame(0);
    pend[0] = 1;
    pend[3] = 1;
    wait_acks(2);
    mute_sends = 1;
    expect_frame(1);
    expect_frame(2);
    pend[1] = 1;
    pend[2] = 1;
    wait_acks(2);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", err, 1);
    do_reset();
    check("err_cleared", err, 0);
    chk_gap = 1'b0;
    expect_frame(2);
    pend[2] = 1;
    wait_acks(1);
    expect_frame(3);
    pend[3] = 1;
    wait_grant(4'b1000);
    repeat (5) @(posedge clk);
    #2;
    pend[1] = 1;
    rst_n = 1'b0;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_ack", ack, 0);
    check("midrst_tx_send", tx_send, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_err", err, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    expect_frame(1);
    expect_frame(3);
    wait_acks(2);
    expect_frame(2);
    pend[2] = 1;
    wait_grant(4'b0100);
    pend[2] = 0;
    wait_acks(1);
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    check("end_grant", grant, 0);
    check("end_err", err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 8-bit serial transmitter among NUM_REQ byte-producing clients. It latches the granted client's byte, drives the transmitter's send/data inputs, and tracks the transmitter's busy (transmission) output until the frame completes. It then acks the client and enforces an inter-frame gap. It sits between client logic and the serial transmitter in the transmit path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 2, idle clk cycles forced between frames (0..15)
START_TIMEOUT, 8, clk cycles to wait for busy to rise after send before declaring error (1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-client request, level; held until ack
req_data  input  8*NUM_REQ  per-client byte, client i at bits [8i+7:8i]
ack  output  NUM_REQ  one-cycle pulse to the client whose byte completed transmission
grant  output  NUM_REQ  one-hot, client currently owning the transmitter; 0 when idle
tx_send  output  1  send strobe to transmitter, registered
tx_data  output  8  byte to transmitter, registered, stable while grant nonzero
tx_busy  input  1  transmitter's transmission output, high while frame shifts out
err  output  1  sticky: transmitter failed to start within START_TIMEOUT; cleared only by reset

Behaviour:
- Reset (async assert, sync deassert internally via two-flop): state IDLE, grant=0, ack=0, tx_send=0, tx_data=0, err=0, rr pointer=0, counters=0. Reset mid-frame abandons the frame with no ack.
- States: IDLE, LOAD, SEND, WAIT_START, WAIT_DONE, GAP.
- IDLE: if any req bit is set, pick the first set bit at or above the rr pointer, wrapping modulo NUM_REQ. Set the one-hot grant and latch its byte into tx_data. Go to LOAD. Arbitration takes one cycle from req sampled high to grant.
- LOAD: tx_data stable for one cycle (setup for the transmitter's send-edge capture) -> SEND.
- SEND: tx_send=1 for exactly one cycle; timeout counter cleared -> WAIT_START.
- WAIT_START: tx_busy=1 -> WAIT_DONE. Timeout counter reaching START_TIMEOUT -> set err, ack the client anyway, advance rr, go to GAP.
- WAIT_DONE: tx_busy falls to 0 -> ack[granted]=1 for one cycle, grant=0, rr pointer = granted index+1 (wraps), go to GAP. If GAP_CYCLES=0, go directly to IDLE.
- GAP: counts GAP_CYCLES cycles, then IDLE. req is ignored during GAP.
- A client that has been granted and acked then keeps req high is not regranted while other clients request (round-robin fairness). It is regranted next if it is the only requester.
- Dropping req after grant does not cancel the frame. The ack is still issued.
- tx_busy high while in IDLE/LOAD is tolerated: SEND still occurs and busy is treated as this frame's start.
- The worst-case wait for any continuously requesting client is (NUM_REQ-1) frames.
- Widths: the rr pointer is clog2(NUM_REQ) bits. The timeout counter is 8 bits. The gap counter is 4 bits. No overflow is possible given the parameter ranges.

Decomposition:
- Shared package serial_tx_pkg: state encoding constants (3-bit), default GAP/timeout constants, and a byte-width constant of 8 shared with the transmitter.
- One sub-module, rr_priority_pick: combinational find-first-set starting at the rr pointer with wrap. It outputs a one-hot grant and an index. It is reused by future arbiters.
- The FSM, counters and data latch stay in serial_tx_arbiter.

Test Plan:
- Single requester: req[1]=1, byte 8'hA5; model busy for 8 cycles. Expect grant=4'b0010 one cycle later, tx_data=A5, a single tx_send pulse, ack[1] pulse the cycle after busy falls, then GAP_CYCLES idle cycles.
- Contention: req=4'b1111 held, bytes 11/22/33/44. Expect service order 0,1,2,3,0 and transmitted bytes 11,22,33,44,11, with exactly one ack per frame.
- Fairness wrap: rr pointer at 3, req=4'b1001. Expect client 3 granted, then client 0.
- Timeout: busy never rises. Expect err=1 exactly START_TIMEOUT cycles after tx_send, ack issued, and the next requester served. err stays 1 until rst_n=0.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE. Expect all outputs 0 immediately (asynchronous), no ack, and a fresh arbitration starting from client 0 after release.
- Req dropped after grant: req[2] goes 1 then 0 in LOAD. Expect the frame still sent and ack[2] pulsed.
